// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, keeps one instruction-memory request in flight, applies BTB
// predictions and EX redirects, and parks a response in a one-entry skid
// buffer when decode is stalled.
//
// Memory handshake: imem_req_o is held with a stable imem_addr_o until a
// cycle with imem_gnt_i=1 completes it; exactly one request is outstanding;
// its data returns with imem_rvalid_i=1 in some later cycle.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        reset_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] btb_pc_o,
  input  logic        btb_hit_i,
  input  logic [31:0] btb_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_d_o,
  output logic [31:0] pc_d_o,
  output logic [31:0] pc4_d_o,
  output logic        hit_d_o,
  output logic        valid_d_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_hit_q, req_hit_d;
  logic        drop_q, drop_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_hit_q, buf_hit_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_hit_q, id_hit_d;
  logic        id_valid_q, id_valid_d;
  logic        rsp_take;  // live response goes straight into IF/ID
  logic        buf_take;  // skid buffer drains into IF/ID

  assign btb_pc_o    = pc_q;
  assign imem_addr_o = pc_q;
  assign dbg_state_o = state_q;
  assign inst_d_o    = id_inst_q;
  assign pc_d_o      = id_pc_q;
  assign pc4_d_o     = id_pc4_q;
  assign hit_d_o     = id_hit_q;
  assign valid_d_o   = id_valid_q;

  // Fetch FSM next state, PC selection, drop tracking and skid-buffer writes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    req_hit_d  = req_hit_q;
    drop_d     = drop_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    buf_hit_d  = buf_hit_q;
    rsp_take   = 1'b0;
    buf_take   = 1'b0;
    imem_req_o = 1'b0;
    unique case (state_q)
      S_REQ: begin
        imem_req_o = !rst_i;
        if (imem_gnt_i) begin
          req_pc_d  = pc_q;
          req_hit_d = btb_hit_i;
          state_d   = S_WAIT;
          pc_d      = btb_hit_i ? btb_target_i : pc_q + 32'd4;
          // A redirect in the grant cycle makes this fetch stale.
          if (br_taken_i) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (br_taken_i) begin
            // data belongs to the wrong path; discard it
          end else if (enable_i) begin
            rsp_take = 1'b1;
          end else begin
            buf_inst_d = imem_rdata_i;
            buf_pc_d   = req_pc_q;
            buf_hit_d  = req_hit_q;
            state_d    = S_FULL;
          end
        end else if (br_taken_i) begin
          drop_d = 1'b1;
        end
      end
      S_FULL: begin
        if (br_taken_i) begin
          state_d = S_REQ;
        end else if (enable_i) begin
          buf_take = 1'b1;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    // An EX redirect overrides both the BTB and the sequential PC.
    if (br_taken_i) pc_d = br_target_i;
  end

  // IF/ID next value: hold when stalled, otherwise bubble unless a real instruction is ready.
  always_comb begin
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_hit_d   = id_hit_q;
    id_valid_d = id_valid_q;
    if (enable_i) begin
      id_inst_d  = NOP_INST;
      id_pc_d    = 32'd0;
      id_pc4_d   = 32'd0;
      id_hit_d   = 1'b0;
      id_valid_d = 1'b0;
      if (!reset_i && !br_taken_i) begin
        if (rsp_take) begin
          id_inst_d  = imem_rdata_i;
          id_pc_d    = req_pc_q;
          id_pc4_d   = req_pc_q + 32'd4;
          id_hit_d   = req_hit_q;
          id_valid_d = 1'b1;
        end else if (buf_take) begin
          id_inst_d  = buf_inst_q;
          id_pc_d    = buf_pc_q;
          id_pc4_d   = buf_pc_q + 32'd4;
          id_hit_d   = buf_hit_q;
          id_valid_d = 1'b1;
        end
      end
    end
  end

  // State, PC, request bookkeeping, skid buffer and IF/ID registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      req_hit_q  <= 1'b0;
      drop_q     <= 1'b0;
      buf_inst_q <= 32'd0;
      buf_pc_q   <= 32'd0;
      buf_hit_q  <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_hit_q   <= 1'b0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      req_hit_q  <= req_hit_d;
      drop_q     <= drop_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      buf_hit_q  <= buf_hit_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_hit_q   <= id_hit_d;
      id_valid_q <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory + BTB models, directed scenarios, then random
// stalls/redirects checked against the program-order fetch stream.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [1:0]  ST_REQ   = 2'd0;
  localparam logic [1:0]  ST_WAIT  = 2'd1;
  localparam logic [1:0]  ST_FULL  = 2'd2;

  logic        clk_i = 1'b0;
  logic        rst_i, enable_i, reset_i, br_taken_i;
  logic [31:0] br_target_i;
  logic [31:0] btb_pc_o;
  logic        btb_hit_i;
  logic [31:0] btb_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_d_o, pc_d_o, pc4_d_o;
  logic        hit_d_o, valid_d_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int deliv_cnt = 0;

  // memory / monitor shared state
  bit          rand_mode = 1'b0;
  int          fix_delay = 0;
  bit          sb_hold = 1'b0;
  bit          mem_out = 1'b0;
  logic [31:0] mem_addr;
  int          mem_wait;
  bit          prev_en, prev_req, prev_gnt, prev_br;
  logic [31:0] prev_addr;
  logic [31:0] mon_p;
  logic [31:0] exp_q[$];

  if_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .reset_i(reset_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .btb_pc_o(btb_pc_o), .btb_hit_i(btb_hit_i), .btb_target_i(btb_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_d_o(inst_d_o), .pc_d_o(pc_d_o), .pc4_d_o(pc4_d_o),
    .hit_d_o(hit_d_o), .valid_d_o(valid_d_o), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference program / BTB ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic btb_hit_of(input logic [31:0] a);
    return (a == 32'h20) || (a == 32'h9C) || (a == 32'hFFFF_FFF8);
  endfunction

  function automatic logic [31:0] btb_tgt_of(input logic [31:0] a);
    case (a)
      32'h20:        return 32'h80;
      32'h9C:        return 32'h40;
      32'hFFFF_FFF8: return 32'h10;
      default:       return 32'hDEAD_BEE0;
    endcase
  endfunction

  assign btb_hit_i    = btb_hit_of(btb_pc_o);
  assign btb_target_i = btb_tgt_of(btb_pc_o);

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // called at a negedge; returns at the negedge where IF/ID shows pc a
  task automatic wait_out_pc(input logic [31:0] a, input int budget, input string name);
    int n = 0;
    while (!(valid_d_o && pc_d_o == a) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (!(valid_d_o && pc_d_o == a)) begin
      errors++;
      $display("FAIL %s timeout: pc_d_o=%h valid=%b expected pc=%h", name, pc_d_o, valid_d_o, a);
    end
  endtask

  // called at a negedge; returns at the negedge where a request to a is presented
  task automatic wait_req_addr(input logic [31:0] a, input int budget, input string name);
    int n = 0;
    while (!(imem_req_o && imem_addr_o == a) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (!(imem_req_o && imem_addr_o == a)) begin
      errors++;
      $display("FAIL %s timeout: req=%b addr=%h expected addr=%h", name, imem_req_o, imem_addr_o, a);
    end
  endtask

  // ---------------- instruction memory model ----------------
  initial begin
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    forever begin
      @(posedge clk_i);
      #2;
      if (rst_i) begin
        mem_out = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      end else begin
        if (imem_gnt_i && prev_req) begin
          mem_out  = 1'b1;
          mem_addr = prev_addr;
          mem_wait = rand_mode ? int'($urandom_range(0, 2)) : fix_delay;
        end
        imem_rvalid_i = 1'b0;
        if (mem_out) begin
          if (mem_wait == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_addr);
            mem_out       = 1'b0;
          end else begin
            mem_wait--;
          end
        end
        imem_gnt_i = imem_req_o && (!rand_mode || $urandom_range(0, 2) != 0);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        prev_en = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0; prev_br = 1'b0;
      end else begin
        if (prev_en && valid_d_o) begin
          deliv_cnt++;
          if (!sb_hold) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL sb_empty actual pc=%h expected none queued", pc_d_o);
            end else begin
              mon_p = exp_q.pop_front();
              chk("sb_pc", pc_d_o, mon_p);
              chk("sb_pc4", pc4_d_o, mon_p + 32'd4);
              chk("sb_inst", inst_d_o, mem_word(mon_p));
              chk("sb_hit", {31'd0, hit_d_o}, {31'd0, btb_hit_of(mon_p)});
              exp_q.push_back(btb_hit_of(mon_p) ? btb_tgt_of(mon_p) : mon_p + 32'd4);
            end
          end
        end
        if (prev_req && !prev_gnt && !prev_br && imem_req_o)
          chk("req_addr_stable", imem_addr_o, prev_addr);
        chk("one_outstanding", {31'd0, imem_req_o && (mem_out || imem_rvalid_i)}, 32'd0);
        if (br_taken_i) begin
          exp_q.delete();
          exp_q.push_back(br_target_i);
        end
        prev_en = enable_i; prev_req = imem_req_o; prev_gnt = imem_gnt_i;
        prev_br = br_taken_i; prev_addr = imem_addr_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; enable_i = 1'b1; reset_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_inst", inst_d_o, NOP);
    chk("rst_pc", pc_d_o, 32'd0);
    chk("rst_pc4", pc4_d_o, 32'd0);
    chk("rst_hit", {31'd0, hit_d_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_d_o}, 32'd0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_REQ});
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("first_req_addr", imem_addr_o, RESET_PC);

    // sequential fetch, two cycles per instruction
    wait_out_pc(32'h0, 10, "seq_pc0");
    chk("seq0_inst", inst_d_o, 32'h0010_0093);
    chk("seq0_pc4", pc4_d_o, 32'h4);
    chk("seq0_hit", {31'd0, hit_d_o}, 32'd0);
    @(negedge clk_i);
    chk("seq_gap_valid", {31'd0, valid_d_o}, 32'd0);
    @(negedge clk_i);
    chk("seq1_valid", {31'd0, valid_d_o}, 32'd1);
    chk("seq1_pc", pc_d_o, 32'h4);
    chk("seq1_pc4", pc4_d_o, 32'h8);
    chk("seq1_inst", inst_d_o, 32'h0020_0113);
    chk("req8_addr", imem_addr_o, 32'h8);

    // stall while the response for pc 8 returns
    tick();
    enable_i = 1'b0;
    @(negedge clk_i);
    chk("stall_c0_valid", {31'd0, valid_d_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        tick();
        enable_i = 1'b1;
      end else begin
        tick();
      end
      @(negedge clk_i);
      chk("stall_state", {30'd0, dbg_state}, {30'd0, ST_FULL});
      chk("stall_req", {31'd0, imem_req_o}, 32'd0);
      chk("stall_hold_valid", {31'd0, valid_d_o}, 32'd0);
      chk("stall_hold_inst", inst_d_o, NOP);
      chk("stall_hold_pc", pc_d_o, 32'd0);
    end
    @(negedge clk_i);
    chk("unstall_valid", {31'd0, valid_d_o}, 32'd1);
    chk("unstall_pc", pc_d_o, 32'h8);
    chk("unstall_pc4", pc4_d_o, 32'hC);
    chk("unstall_inst", inst_d_o, mem_word(32'h8));
    chk("unstall_req", {31'd0, imem_req_o}, 32'd1);
    chk("unstall_addr", imem_addr_o, 32'hC);

    // redirect one cycle before rvalid
    fix_delay = 1;
    wait_req_addr(32'h10, 12, "req10");
    tick();
    br_taken_i = 1'b1; br_target_i = 32'h100;
    tick();
    br_taken_i = 1'b0;
    @(negedge clk_i);
    chk("redir_bubble", {31'd0, valid_d_o}, 32'd0);
    chk("redir_wait_req", {31'd0, imem_req_o}, 32'd0);
    @(negedge clk_i);
    chk("redir_drop_valid", {31'd0, valid_d_o}, 32'd0);
    chk("redir_req", {31'd0, imem_req_o}, 32'd1);
    chk("redir_addr", imem_addr_o, 32'h100);
    fix_delay = 0;
    wait_out_pc(32'h100, 10, "redir_pc100");
    chk("redir_inst", inst_d_o, mem_word(32'h100));

    // BTB hit at 0x20 -> 0x80
    tick();
    br_taken_i = 1'b1; br_target_i = 32'h20;
    tick();
    br_taken_i = 1'b0;
    @(negedge clk_i);
    wait_out_pc(32'h20, 12, "btb_pc20");
    chk("btb_hit_d", {31'd0, hit_d_o}, 32'd1);
    chk("btb_pc4", pc4_d_o, 32'h24);
    chk("btb_next_req", {31'd0, imem_req_o}, 32'd1);
    chk("btb_next_addr", imem_addr_o, 32'h80);

    // flush while the 0x80 response arrives
    sb_hold = 1'b1;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("flush_inst", inst_d_o, NOP);
    chk("flush_valid", {31'd0, valid_d_o}, 32'd0);
    chk("flush_pc", pc_d_o, 32'd0);
    chk("flush_next_addr", imem_addr_o, 32'h84);

    // async reset while waiting for 0x84
    fix_delay = 2;
    tick();
    rst_i = 1'b1;
    #1;
    chk("arst_inst", inst_d_o, NOP);
    chk("arst_pc", pc_d_o, 32'd0);
    chk("arst_pc4", pc4_d_o, 32'd0);
    chk("arst_valid", {31'd0, valid_d_o}, 32'd0);
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk("arst_state", {30'd0, dbg_state}, {30'd0, ST_REQ});
    sb_hold = 1'b0;
    fix_delay = 0;
    tick();
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rerst_req", {31'd0, imem_req_o}, 32'd1);
    chk("rerst_addr", imem_addr_o, RESET_PC);
    wait_out_pc(RESET_PC, 10, "rerst_pc0");
    chk("rerst_inst", inst_d_o, 32'h0010_0093);

    // wrap at the top of the address space
    tick();
    br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
    tick();
    br_taken_i = 1'b0;
    @(negedge clk_i);
    wait_out_pc(32'hFFFF_FFFC, 12, "wrap_pc");
    chk("wrap_pc4", pc4_d_o, 32'h0);
    chk("wrap_inst", inst_d_o, mem_word(32'hFFFF_FFFC));
    chk("wrap_next_addr", imem_addr_o, 32'h0);

    // random stalls, grant/response latencies and redirects
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      enable_i   = ($urandom_range(0, 3) != 0);
      br_taken_i = ($urandom_range(0, 15) == 0);
      reset_i    = 1'b0;
      if (br_taken_i) begin
        if ($urandom_range(0, 1) == 1) br_target_i = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        else br_target_i = 32'hFFFF_FFC0 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        reset_i = ($urandom_range(0, 1) == 1);
      end
    end
    tick();
    enable_i = 1'b1; br_taken_i = 1'b0; reset_i = 1'b0;
    repeat (20) tick();
    @(negedge clk_i);
    chk("deliveries_seen", {31'd0, deliv_cnt > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the RV32 core. It sits directly upstream of the decode stage. It owns the PC, issues one instruction-memory request at a time, and applies BTB predictions and EX-stage redirects. Its registered outputs (inst_d_o, pc_d_o, pc4_d_o, hit_d_o) feed decode unchanged. Stall and flush controls come from the hazard unit, with the same meaning as at every other stage register.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, instruction injected on bubbles/flushes (addi x0,x0,0)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  hazard unit: 1 = IF/ID register may update, 0 = hold
- reset_i  in  1  hazard unit flush: load bubble into IF/ID (sampled only when enable_i=1)
- br_taken_i  in  1  EX redirect (mispredict/jump) valid
- br_target_i  in  32  EX redirect target
- btb_pc_o  out  32  lookup address to BTB (= pc_q)
- btb_hit_i  in  1  BTB hit for btb_pc_o (combinational)
- btb_target_i  in  32  predicted target on hit
- imem_req_o  out  1  instruction request
- imem_addr_o  out  32  request address (= pc_q)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  read data valid
- imem_rdata_i  in  32  instruction word
- inst_d_o  out  32  IF/ID instruction
- pc_d_o  out  32  IF/ID PC
- pc4_d_o  out  32  IF/ID PC+4
- hit_d_o  out  1  IF/ID BTB-hit flag for that instruction
- valid_d_o  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc_q, req_pc_q, req_hit_q, drop_q, a one-entry skid buffer (buf_inst_q/buf_pc_q/buf_hit_q), FSM state, IF/ID outputs.
- FSM REQ:
  - imem_req_o=1 (forced 0 while rst_i).
  - On imem_gnt_i: capture req_pc_q=pc_q and req_hit_q=btb_hit_i, then go to WAIT.
  - Next pc_q = btb_hit_i ? btb_target_i : pc_q+4.
- FSM WAIT: imem_req_o=0. On imem_rvalid_i:
  - drop_q=1: discard the data, clear drop_q, go to REQ.
  - else if enable_i=1: load IF/ID, go to REQ.
  - else: write the skid buffer, go to FULL.
- FSM FULL: imem_req_o=0. When enable_i=1, load IF/ID from the buffer and go to REQ.
- Redirect (br_taken_i=1) has priority over the BTB and the sequential PC:
  - pc_q <= br_target_i.
  - In REQ with gnt the same cycle: the granted fetch is stale; go to WAIT with drop_q=1.
  - In WAIT without rvalid: set drop_q=1. In WAIT with rvalid: discard the data and go to REQ.
  - In FULL: discard the buffer and go to REQ.
  - The IF/ID register loads a bubble if enable_i=1.
- IF/ID update (only when enable_i=1), in priority order:
  - reset_i or br_taken_i → bubble.
  - else an accepted non-dropped response or the FULL buffer → inst, pc=req_pc/buf_pc, pc4=pc+4, hit, valid=1.
  - else → bubble.
- Bubble: inst=NOP_INST, pc=0, pc4=0, hit=0, valid=0.
- enable_i=0: IF/ID holds every bit. reset_i is ignored while enable_i=0.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC → 0x0000_0000). PC bits [1:0] are not checked.

## Timing
- Reset (async assert, released synchronously to clk_i):
  - state=REQ, pc_q=RESET_PC, drop_q=0, buffer empty.
  - inst_d_o=NOP_INST, pc_d_o=0, pc4_d_o=0, hit_d_o=0, valid_d_o=0, imem_req_o=0.
- Reset asserted mid-transaction: any outstanding response is abandoned. The memory is also reset by rst_i. After release, the first request goes to RESET_PC.
- Handshake:
  - Request is held, with a stable address, until gnt.
  - One outstanding request.
  - rvalid arrives no earlier than the cycle after gnt.
- Latency: gnt in cycle N, rvalid in N+1, IF/ID visible in N+2. Peak throughput is 1 instruction per 2 cycles.
- A redirect in cycle N issues its request to br_target_i in N+1, or after the dropped rvalid arrives.
- A BTB lookup uses the address on btb_pc_o in the same cycle as the gnt.

## Test plan
- Sequential fetch: RESET_PC=0, gnt/rvalid one cycle apart, words 0x00100093, 0x00200113 → IF/ID (pc,pc4,valid) = (0,4,1), then (4,8,1), 2 cycles apart.
- Stall: enable_i=0 for 3 cycles when rvalid returns inst at pc 8 → FSM in FULL, no new request, IF/ID unchanged; enable_i=1 → inst at 8 loads next edge, request to 0xC follows.
- Redirect during WAIT: br_taken_i=1, target 0x100, one cycle before rvalid → returned word dropped, valid_d_o=0, next request addr=0x100, next valid instruction has pc_d_o=0x100.
- BTB hit: at pc 0x20, btb_hit_i=1, target 0x80 → next request addr=0x80, IF/ID for pc 0x20 has hit_d_o=1.
- Flush and reset: reset_i=1 with enable_i=1 while a response arrives → inst_d_o=0x00000013, valid=0. Then rst_i asserted in WAIT → all outputs at reset values immediately, imem_req_o=0, first request after release to RESET_PC.
- Wrap: fetch at 0xFFFF_FFFC → pc4_d_o=0x0000_0000, next request addr=0.
